if_fetch_ctrl: RTL and testbench

- Instruction-fetch front end. Issues PCs on the SRAM-like inst_sram request channel and tracks in-flight fetches. Buffers returned instructions and presents them to ID with a valid/allow_in handshake.
- Owns cancellation of wrong-path fetches. On a redirect (exception or taken branch), every response belonging to a request accepted before the redirect is discarded. No data from such a request ever reaches ID.

---
 rtl/if_fetch_ctrl_pkg.sv | 14 +
 rtl/if_fetch_ctrl_fifo.sv | 64 ++++++
 rtl/if_fetch_ctrl.sv | 150 +++++++++++++++
 tb/tb_if_fetch_ctrl.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/if_fetch_ctrl_pkg.sv
// Shared types and constants for the instruction-fetch front end.
// Inflight entries carry the fetch PC and a wrong-path kill flag.
package if_fetch_ctrl_pkg;

    localparam logic [31:0] RESET_PC_DEF = 32'h1c000000;
    localparam int          INST_W       = 32;
    localparam logic [31:0] PC_INC       = 32'd4;

    typedef struct packed {
        logic [31:0] pc;
        logic        kill;
    } inflight_t;

endpackage

// File: rtl/if_fetch_ctrl_fifo.sv
// Synchronous FIFO with whole-queue flush and a kill-all that sets
// one flag bit in every stored entry.
module fetch_fifo #(
    parameter int W        = 32,
    parameter int DEPTH    = 2,
    parameter int KILL_BIT = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_push,
    input  logic [W-1:0]           i_din,
    input  logic                   i_pop,
    input  logic                   i_flush,
    input  logic                   i_kill_all,
    output logic [W-1:0]           o_dout,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_rp;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_flush) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (i_kill_all) begin
                for (int i = 0; i < DEPTH; i++) begin
                    r_mem[i][KILL_BIT] <= 1'b1;
                end
            end
            // A push in the kill cycle carries its own kill bit in i_din
            if (i_push) begin
                r_mem[r_wp] <= i_din;
                r_wp        <= r_wp + 1'b1;
            end
            if (i_pop) begin
                r_rp <= r_rp + 1'b1;
            end
            r_cnt <= r_cnt + CW'(i_push) - CW'(i_pop);
        end
    end

    assign o_dout  = r_mem[r_rp];
    assign o_full  = (r_cnt == CW'(DEPTH));
    assign o_empty = (r_cnt == '0);
    assign o_count = r_cnt;

endmodule

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch front end: issues PCs, tracks inflight fetches,
// buffers responses for ID and discards wrong-path data on redirect.
module if_fetch_ctrl
    import if_fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter int          MAX_OUT  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect,
    input  logic [31:0]       redirect_pc,
    input  logic              id_allow_in,
    output logic              inst_sram_req,
    output logic [31:0]       inst_sram_addr,
    input  logic              inst_sram_addr_ok,
    input  logic              inst_sram_data_ok,
    input  logic [INST_W-1:0] inst_sram_rdata,
    output logic              if_to_id_valid,
    output logic [31:0]       if_to_id_pc,
    output logic [INST_W-1:0] if_to_id_inst
);

    localparam int CW = $clog2(MAX_OUT) + 1;
    localparam int RW = 32 + INST_W;

    logic        r_req;
    logic [31:0] r_pc;
    logic        r_pend;
    logic [31:0] r_pend_pc;

    logic          w_accept;
    inflight_t     w_infl_din;
    inflight_t     w_infl_head;
    logic          w_infl_full;
    logic          w_infl_empty;
    logic [CW-1:0] w_infl_cnt;
    logic          w_resp_push;
    logic          w_resp_pop;
    logic [RW-1:0] w_resp_head;
    logic          w_resp_full;
    logic          w_resp_empty;
    logic [CW-1:0] w_resp_cnt;
    logic [CW:0]   w_infl_nxt;
    logic [CW:0]   w_resp_nxt;
    logic          w_req_nxt;
    logic [31:0]   w_pc_nxt;
    logic          w_pend_nxt;
    logic [31:0]   w_pend_pc_nxt;

    assign w_accept   = r_req & inst_sram_addr_ok;
    assign w_infl_din = inflight_t'{pc: r_pc, kill: r_pend | redirect};

    assign w_resp_push = inst_sram_data_ok & ~w_infl_head.kill & ~redirect;
    assign if_to_id_valid = ~w_resp_empty & ~redirect;
    assign w_resp_pop     = if_to_id_valid & id_allow_in;
    assign if_to_id_pc    = w_resp_head[RW-1:INST_W];
    assign if_to_id_inst  = w_resp_head[INST_W-1:0];

    assign inst_sram_req  = r_req;
    assign inst_sram_addr = r_pc;

    fetch_fifo #(
        .W        ($bits(inflight_t)),
        .DEPTH    (MAX_OUT),
        .KILL_BIT (0)
    ) u_inflight (
        .clk        (clk),
        .rst        (rst),
        .i_push     (w_accept),
        .i_din      (w_infl_din),
        .i_pop      (inst_sram_data_ok),
        .i_flush    (1'b0),
        .i_kill_all (redirect),
        .o_dout     (w_infl_head),
        .o_full     (w_infl_full),
        .o_empty    (w_infl_empty),
        .o_count    (w_infl_cnt)
    );

    fetch_fifo #(
        .W        (RW),
        .DEPTH    (MAX_OUT),
        .KILL_BIT (0)
    ) u_resp (
        .clk        (clk),
        .rst        (rst),
        .i_push     (w_resp_push),
        .i_din      ({w_infl_head.pc, inst_sram_rdata}),
        .i_pop      (w_resp_pop),
        .i_flush    (redirect),
        .i_kill_all (1'b0),
        .o_dout     (w_resp_head),
        .o_full     (w_resp_full),
        .o_empty    (w_resp_empty),
        .o_count    (w_resp_cnt)
    );

    always_comb begin
        w_pc_nxt      = r_pc;
        w_pend_nxt    = r_pend;
        w_pend_pc_nxt = r_pend_pc;
        w_infl_nxt = {1'b0, w_infl_cnt} + (CW+1)'(w_accept)
                   - (CW+1)'(inst_sram_data_ok);
        w_resp_nxt = redirect ? '0
                   : {1'b0, w_resp_cnt} + (CW+1)'(w_resp_push)
                   - (CW+1)'(w_resp_pop);
        // Only issue when every possible response already owns a slot
        w_req_nxt = (r_req & ~inst_sram_addr_ok)
                  | ((w_infl_nxt + w_resp_nxt) < (CW+1)'(MAX_OUT));
        if (w_accept) begin
            w_pend_nxt = 1'b0;
            if (redirect)
                w_pc_nxt = redirect_pc;
            else if (r_pend)
                w_pc_nxt = r_pend_pc;
            else
                w_pc_nxt = r_pc + PC_INC;
        end else if (redirect && r_req) begin
            w_pend_nxt    = 1'b1;
            w_pend_pc_nxt = redirect_pc;
        end else if (redirect) begin
            w_pc_nxt = redirect_pc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_req     <= 1'b0;
            r_pc      <= RESET_PC;
            r_pend    <= 1'b0;
            r_pend_pc <= '0;
        end else begin
            r_req     <= w_req_nxt;
            r_pc      <= w_pc_nxt;
            r_pend    <= w_pend_nxt;
            r_pend_pc <= w_pend_pc_nxt;
        end
    end

    a_dok_empty: assert property (@(posedge clk) disable iff (rst)
        inst_sram_data_ok |-> !w_infl_empty);
    a_infl_ovf: assert property (@(posedge clk) disable iff (rst)
        (w_accept && w_infl_full) |-> inst_sram_data_ok);
    a_resp_ovf: assert property (@(posedge clk) disable iff (rst)
        (w_resp_push && w_resp_full) |-> w_resp_pop);
    a_resp_udf: assert property (@(posedge clk) disable iff (rst)
        w_resp_pop |-> !w_resp_empty);

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Self-checking bench for if_fetch_ctrl: SRAM responder, PC model
// and a scoreboard of PCs expected at the ID interface.
module tb_if_fetch_ctrl;

    logic        clk;
    logic        rst;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        id_allow_in;
    logic        inst_sram_req;
    logic [31:0] inst_sram_addr;
    logic        inst_sram_addr_ok;
    logic        inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;
    logic        if_to_id_valid;
    logic [31:0] if_to_id_pc;
    logic [31:0] if_to_id_inst;

    if_fetch_ctrl #(
        .RESET_PC (32'h1c000000),
        .MAX_OUT  (2)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .redirect          (redirect),
        .redirect_pc       (redirect_pc),
        .id_allow_in       (id_allow_in),
        .inst_sram_req     (inst_sram_req),
        .inst_sram_addr    (inst_sram_addr),
        .inst_sram_addr_ok (inst_sram_addr_ok),
        .inst_sram_data_ok (inst_sram_data_ok),
        .inst_sram_rdata   (inst_sram_rdata),
        .if_to_id_valid    (if_to_id_valid),
        .if_to_id_pc       (if_to_id_pc),
        .if_to_id_inst     (if_to_id_inst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic aok;
        logic dok;
        logic allow;
        logic exp_req;
        logic exp_valid;
    } vec_t;

    int checks;
    int failures;

    logic [31:0] mq[$];
    logic [31:0] eq[$];

    logic [31:0] m_pc;
    logic        m_pend;
    logic [31:0] m_pend_pc;
    logic        s_req;
    logic        s_valid;
    logic        want_en;
    logic [31:0] want_pc;

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return a ^ 32'h5a5a0f0f;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    task automatic cycle(input logic aok, input logic dok,
                         input logic allow, input logic redir,
                         input logic [31:0] rpc);
        logic        acc;
        logic [31:0] e;
        inst_sram_addr_ok = aok;
        inst_sram_data_ok = dok && (mq.size() > 0);
        inst_sram_rdata   = inst_sram_data_ok ? mem_f(mq[0]) : $urandom;
        id_allow_in       = allow;
        redirect          = redir;
        redirect_pc       = rpc;
        @(negedge clk);
        s_req   = inst_sram_req;
        s_valid = if_to_id_valid;
        if (redir) chk("redir_valid_low", {31'd0, if_to_id_valid}, 32'd0);
        if (if_to_id_valid && allow) begin
            if (eq.size() == 0) begin
                chk("unexpected_delivery", if_to_id_pc, 32'hffffffff);
            end else begin
                e = eq.pop_front();
                chk("id_pc", if_to_id_pc, e);
                chk("id_inst", if_to_id_inst, mem_f(e));
                if (want_en) begin
                    chk("first_pc_after_redir", if_to_id_pc, want_pc);
                    want_en = 1'b0;
                end
            end
        end
        if (inst_sram_data_ok) void'(mq.pop_front());
        if (inst_sram_req) chk("req_addr", inst_sram_addr, m_pc);
        acc = inst_sram_req && aok;
        if (acc) mq.push_back(inst_sram_addr);
        if (redir) eq.delete();
        if (acc) begin
            if (!(redir || m_pend)) eq.push_back(m_pc);
            m_pc   = redir ? rpc : (m_pend ? m_pend_pc : m_pc + 32'd4);
            m_pend = 1'b0;
        end else if (redir) begin
            if (inst_sram_req) begin
                m_pend    = 1'b1;
                m_pend_pc = rpc;
            end else begin
                m_pc = rpc;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
    endtask

    task automatic run_to(input logic [31:0] pc);
        want_en = 1'b1;
        want_pc = pc;
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'd0);
        chk("first_delivery_seen", {31'd0, want_en}, 32'd0);
    endtask

    vec_t vt[17];

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks    = 0;
        failures  = 0;
        m_pc      = 32'h1c000000;
        m_pend    = 1'b0;
        m_pend_pc = '0;
        want_en   = 1'b0;
        want_pc   = '0;

        vt[0]  = '{1, 1, 1, 0, 0};
        vt[1]  = '{1, 1, 1, 1, 0};
        vt[2]  = '{1, 1, 1, 1, 0};
        vt[3]  = '{1, 1, 1, 0, 1};
        vt[4]  = '{1, 1, 1, 1, 1};
        vt[5]  = '{1, 1, 1, 1, 0};
        vt[6]  = '{1, 1, 1, 0, 1};
        vt[7]  = '{0, 1, 1, 1, 1};
        vt[8]  = '{0, 1, 1, 1, 0};
        vt[9]  = '{0, 1, 1, 1, 0};
        vt[10] = '{1, 1, 1, 1, 0};
        vt[11] = '{1, 1, 0, 1, 0};
        vt[12] = '{1, 1, 0, 0, 1};
        vt[13] = '{1, 1, 0, 0, 1};
        vt[14] = '{1, 1, 1, 0, 1};
        vt[15] = '{1, 1, 1, 1, 1};
        vt[16] = '{1, 1, 1, 1, 0};

        rst               = 1'b1;
        redirect          = 1'b0;
        redirect_pc       = '0;
        id_allow_in       = 1'b0;
        inst_sram_addr_ok = 1'b0;
        inst_sram_data_ok = 1'b0;
        inst_sram_rdata   = '0;
        @(negedge clk);
        chk("rst_req", {31'd0, inst_sram_req}, 32'd0);
        chk("rst_valid", {31'd0, if_to_id_valid}, 32'd0);
        chk("rst_id_pc", if_to_id_pc, 32'd0);
        chk("rst_id_inst", if_to_id_inst, 32'd0);
        chk("rst_addr", inst_sram_addr, 32'h1c000000);
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 17; i++) begin
            cycle(vt[i].aok, vt[i].dok, vt[i].allow, 1'b0, 32'd0);
            chk($sformatf("tbl_req_%0d", i), {31'd0, s_req},
                {31'd0, vt[i].exp_req});
            chk($sformatf("tbl_valid_%0d", i), {31'd0, s_valid},
                {31'd0, vt[i].exp_valid});
        end

        // Two fetches in flight, redirect with no request held
        drain();
        cycle(1'b1, 1'b0, 1'b1, 1'b0, 32'd0);
        cycle(1'b1, 1'b0, 1'b1, 1'b0, 32'd0);
        cycle(1'b1, 1'b0, 1'b1, 1'b1, 32'h1c000100);
        chk("two_inflight_no_req", {31'd0, s_req}, 32'd0);
        run_to(32'h1c000100);

        // Redirects while a request is held; latest target wins
        drain();
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 32'h1c000300);
        chk("held_req_kept", {31'd0, s_req}, 32'd1);
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 32'h1c000200);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'd0);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
        chk("pend_req", {31'd0, s_req}, 32'd1);
        chk("pend_addr", inst_sram_addr, 32'h1c000200);
        run_to(32'h1c000200);

        // Redirect coincident with data_ok, one response buffered
        drain();
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 32'h1c000400);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
        chk("flushed_valid_a", {31'd0, s_valid}, 32'd0);
        run_to(32'h1c000400);

        // Redirect with the response queue full
        drain();
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
        chk("full_valid", {31'd0, s_valid}, 32'd1);
        chk("full_no_req", {31'd0, s_req}, 32'd0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'h1c000500);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
        chk("flushed_valid_b", {31'd0, s_valid}, 32'd0);
        run_to(32'h1c000500);

        drain();
        chk("sb_empty", eq.size(), 32'd0);
        chk("mem_empty", mq.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
